// File: rtl/change_dispenser.sv
// change_dispenser
// Change-payout unit for the vending machine. On an accepted request it pays
// the given amount one coin per clock, always picking the largest denomination
// that still fits and is in stock, then pulses `done` and reports through
// `short` whether the exact amount was delivered.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      payout request (accepted only when idle)
//   amount     change to pay, in units of 10 gr, sampled with start
//   refill     restock every denomination to INIT_COUNT (only when idle)
//   busy       high while paying
//   done       one-cycle pulse at the end of a payout
//   short      valid with done: 1 = exact change not delivered
//   remaining  unpaid amount, held after done until the next accepted start
//   empty      bit i set when denomination i is out of stock
//              (bit0 = coin_1 ... bit5 = coin_50)
//   coin_*_o   one-cycle coin pulses worth 1, 2, 5, 10, 20, 50 units
module change_dispenser #(
  parameter int AMT_W      = 8,
  parameter int CNT_W      = 4,
  parameter int INIT_COUNT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             refill,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] remaining,
  output logic [5:0]       empty,
  output logic             coin_1_o,
  output logic             coin_2_o,
  output logic             coin_5_o,
  output logic             coin_10_o,
  output logic             coin_20_o,
  output logic             coin_50_o
);

  typedef enum logic {IDLE, PAY} state_t;

  localparam logic [CNT_W-1:0] INIT_CNT = CNT_W'(INIT_COUNT);

  state_t                  state, state_next;
  logic [5:0][CNT_W-1:0]   count;
  logic [5:0]              coins;
  logic                    found;
  logic [2:0]              sel;

  // Value of denomination index i (0 = coin_1 ... 5 = coin_50).
  function automatic logic [AMT_W-1:0] denom(input int i);
    case (i)
      0:       denom = AMT_W'(1);
      1:       denom = AMT_W'(2);
      2:       denom = AMT_W'(5);
      3:       denom = AMT_W'(10);
      4:       denom = AMT_W'(20);
      default: denom = AMT_W'(50);
    endcase
  endfunction

  // Greedy pick: scanning upward, the last qualifying index wins, which is
  // the largest denomination that fits and is in stock.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    found = 1'b0;
    sel   = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (count[i] != '0 && denom(i) <= remaining) begin
        found = 1'b1;
        sel   = 3'(i);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = PAY;
      PAY:     if (!found) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the stock counters are individual flops, not a RAM, so they are
      // reset directly to the full stock along with the rest of the datapath.
      count     <= {6{INIT_CNT}};
      remaining <= '0;
      coins     <= '0;
      done      <= 1'b0;
      short     <= 1'b0;
    end else begin
      coins <= '0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (refill) count <= {6{INIT_CNT}};
          if (start) begin
            remaining <= amount;
            short     <= 1'b0;
          end
        end
        PAY: begin
          if (found) begin
            // d <= remaining and count[d] > 0, so neither can underflow.
            coins[sel] <= 1'b1;
            remaining  <= remaining - denom(int'(sel));
            count[sel] <= count[sel] - CNT_W'(1);
          end else begin
            done  <= 1'b1;
            short <= (remaining != '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == PAY);

  always_comb begin
    empty = '0;
    for (int i = 0; i < 6; i++) empty[i] = (count[i] == '0);
  end

  assign coin_1_o  = coins[0];
  assign coin_2_o  = coins[1];
  assign coin_5_o  = coins[2];
  assign coin_10_o = coins[3];
  assign coin_20_o = coins[4];
  assign coin_50_o = coins[5];

endmodule
